// File: rtl/lsu_data_mem_if.sv
// Data-bus channel interfaces between the load store unit (master) and the
// data memory (slave): c2c_r carries loads, c2c_w carries stores.
interface c2c_r #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] addr;
    logic [3:0]      sel;
    logic            re;
    logic [XLEN-1:0] data;
    logic            ack;

    modport master (output addr, output sel, output re, input data, input ack);
    modport slave  (input addr, input sel, input re, output data, output ack);
endinterface

interface c2c_w #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] addr;
    logic [3:0]      sel;
    logic [XLEN-1:0] data;
    logic            we;
    logic            ack;

    modport master (output addr, output sel, output data, output we, input ack);
    modport slave  (input addr, input sel, input data, input we, output ack);
endinterface

// File: rtl/lsu_data_mem.sv
// Byte-addressed data RAM serving the LSU read/write channels, one request at
// a time, with LATENCY wait states and a single-cycle ack per request.
module lsu_data_mem #(
    parameter int    DEPTH_BYTES = 4096,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = "",
    parameter int    XLEN        = 32
) (
    input logic clk,
    input logic rst,
    c2c_r.slave data_bus_r,
    c2c_w.slave data_bus_w
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    logic [7:0]    mem_r [DEPTH_BYTES];

    state_t        state_r;
    op_t           op_r;
    logic [CW-1:0] cnt_r;
    logic [AW-1:0] addr_r;
    logic [3:0]    sel_r;
    logic [31:0]   wdata_r;
    logic [31:0]   rdata_r;
    logic          rack_r;
    logic          wack_r;

    logic [AW-1:0] op_addr_s;
    logic [3:0]    op_sel_s;
    logic [31:0]   op_wdata_s;
    logic [AW-1:0] lane_addr_s [4];
    logic [31:0]   rd_word_s;
    logic          req_s;
    logic          do_write_s;
    logic          unused_s;

    // Operand source: live bus while idle (zero-latency path), latched copy otherwise
    always_comb begin
        if (state_r == ST_IDLE) begin
            if (data_bus_w.we) begin
                op_addr_s = data_bus_w.addr[AW-1:0];
                op_sel_s  = data_bus_w.sel;
            end else begin
                op_addr_s = data_bus_r.addr[AW-1:0];
                op_sel_s  = data_bus_r.sel;
            end
            op_wdata_s = data_bus_w.data[31:0];
        end else begin
            op_addr_s  = addr_r;
            op_sel_s   = sel_r;
            op_wdata_s = wdata_r;
        end
    end

    // Per-lane byte address (wraps modulo DEPTH_BYTES) and masked read word
    always_comb begin
        rd_word_s = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            lane_addr_s[i] = op_addr_s + AW'(i);
            if (op_sel_s[i]) begin
                rd_word_s[8*i +: 8] = mem_r[lane_addr_s[i]];
            end else begin
                rd_word_s[8*i +: 8] = 8'h00;
            end
        end
    end

    // Request line that must stay high for the operation in flight
    always_comb begin
        if (op_r == OP_WR) begin
            req_s = data_bus_w.we;
        end else begin
            req_s = data_bus_r.re;
        end
    end

    // Array write strobe; reset drops any write not yet performed
    always_comb begin
        do_write_s = 1'b0;
        if (rst) begin
            do_write_s = 1'b0;
        end else if (state_r == ST_IDLE && LATENCY == 0 && data_bus_w.we) begin
            do_write_s = 1'b1;
        end else if (state_r == ST_WAIT && op_r == OP_WR && data_bus_w.we
                     && cnt_r == CW'(1)) begin
            do_write_s = 1'b1;
        end else begin
            do_write_s = 1'b0;
        end
    end

    // Byte-lane write port; contents survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (do_write_s && op_sel_s[i]) begin
                mem_r[lane_addr_s[i]] <= op_wdata_s[8*i +: 8];
            end
        end
    end

    // Request FSM with registered acks and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= OP_RD;
            cnt_r   <= '0;
            addr_r  <= '0;
            sel_r   <= 4'b0000;
            wdata_r <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
            rack_r  <= 1'b0;
            wack_r  <= 1'b0;
        end else begin
            rack_r <= 1'b0;
            wack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (data_bus_w.we || data_bus_r.re) begin
                        addr_r  <= op_addr_s;
                        sel_r   <= op_sel_s;
                        wdata_r <= op_wdata_s;
                        op_r    <= data_bus_w.we ? OP_WR : OP_RD;
                        if (LATENCY == 0) begin
                            if (data_bus_w.we) begin
                                wack_r <= 1'b1;
                            end else begin
                                rack_r  <= 1'b1;
                                rdata_r <= rd_word_s;
                            end
                            state_r <= ST_ACK;
                        end else begin
                            cnt_r   <= CW'(LATENCY);
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!req_s) begin
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r == CW'(1)) begin
                        cnt_r <= '0;
                        if (op_r == OP_WR) begin
                            wack_r <= 1'b1;
                        end else begin
                            rack_r  <= 1'b1;
                            rdata_r <= rd_word_s;
                        end
                        state_r <= ST_ACK;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_bus_r.data = XLEN'(rdata_r);
    assign data_bus_r.ack  = rack_r;
    assign data_bus_w.ack  = wack_r;

    // Upper address bits are ignored by design
    assign unused_s = ^{data_bus_r.addr, data_bus_w.addr, data_bus_w.data};

endmodule

// File: tb/tb_lsu_data_mem.sv
// Self-checking bench: one LATENCY=1 and one LATENCY=3 instance, table-driven
// accesses plus hand sequences for priority, abort and mid-operation reset.
module tb_lsu_data_mem;

    typedef struct {
        bit          wr;
        logic [31:0] rdata;
    } sb_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;

    logic [31:0] r_addr [2];
    logic [3:0]  r_sel  [2];
    logic        r_re   [2];
    logic [31:0] w_addr [2];
    logic [3:0]  w_sel  [2];
    logic [31:0] w_data [2];
    logic        w_we   [2];
    logic        r_ack  [2];
    logic        w_ack  [2];
    logic [31:0] r_data [2];
    logic        prev_any [2];

    sb_t  q0[$];
    sb_t  q1[$];
    vec_t vecs [13];

    int n_checks = 0;
    int n_fail   = 0;

    c2c_r #(.XLEN(32)) bus_r0 ();
    c2c_w #(.XLEN(32)) bus_w0 ();
    c2c_r #(.XLEN(32)) bus_r1 ();
    c2c_w #(.XLEN(32)) bus_w1 ();

    assign bus_r0.addr = r_addr[0];
    assign bus_r0.sel  = r_sel[0];
    assign bus_r0.re   = r_re[0];
    assign bus_w0.addr = w_addr[0];
    assign bus_w0.sel  = w_sel[0];
    assign bus_w0.data = w_data[0];
    assign bus_w0.we   = w_we[0];
    assign bus_r1.addr = r_addr[1];
    assign bus_r1.sel  = r_sel[1];
    assign bus_r1.re   = r_re[1];
    assign bus_w1.addr = w_addr[1];
    assign bus_w1.sel  = w_sel[1];
    assign bus_w1.data = w_data[1];
    assign bus_w1.we   = w_we[1];
    assign r_ack[0]  = bus_r0.ack;
    assign w_ack[0]  = bus_w0.ack;
    assign r_data[0] = bus_r0.data;
    assign r_ack[1]  = bus_r1.ack;
    assign w_ack[1]  = bus_w1.ack;
    assign r_data[1] = bus_r1.data;

    lsu_data_mem #(.DEPTH_BYTES(4096), .LATENCY(1), .INIT_FILE(""), .XLEN(32)) dut1 (
        .clk        (clk),
        .rst        (rst1),
        .data_bus_r (bus_r0),
        .data_bus_w (bus_w0)
    );

    lsu_data_mem #(.DEPTH_BYTES(4096), .LATENCY(3), .INIT_FILE(""), .XLEN(32)) dut3 (
        .clk        (clk),
        .rst        (rst3),
        .data_bus_r (bus_r1),
        .data_bus_w (bus_w1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %08h required %08h", name, act, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expectation of its instance
    always @(negedge clk) begin : monitor
        sb_t e;
        bit  has;
        for (int k = 0; k < 2; k++) begin
            if (r_ack[k] === 1'b1 || w_ack[k] === 1'b1) begin
                check("ack_exclusive", {31'b0, r_ack[k] & w_ack[k]}, 32'h0);
                check("ack_spacing", {31'b0, prev_any[k]}, 32'h0);
                has = 1'b0;
                if (k == 0) begin
                    if (q0.size() > 0) begin
                        e = q0.pop_front();
                        has = 1'b1;
                    end
                end else begin
                    if (q1.size() > 0) begin
                        e = q1.pop_front();
                        has = 1'b1;
                    end
                end
                check("sb_expected", {31'b0, has}, 32'h1);
                if (has) begin
                    check("ack_kind", {31'b0, w_ack[k]}, {31'b0, e.wr});
                    if (r_ack[k]) begin
                        check("rdata", r_data[k], e.rdata);
                    end
                end
            end
            prev_any[k] <= (r_ack[k] === 1'b1) || (w_ack[k] === 1'b1);
        end
    end

    // Count negedges until the selected ack appears, bounded
    task automatic wait_ack(input int k, input bit wr, input int n0, output int n);
        bit seen;
        seen = 1'b0;
        n = n0;
        while (!seen && n < 30) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (wr ? w_ack[k] : r_ack[k]) seen = 1'b1;
        end
    endtask

    // Single request with expected ack latency 1+LATENCY and held read data after
    task automatic do_op(input int k, input bit wr, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wd, input logic [31:0] exp);
        int n;
        sb_t e;
        e.wr = wr;
        e.rdata = exp;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        if (wr) begin
            w_addr[k] = addr; w_sel[k] = sel; w_data[k] = wd; w_we[k] = 1'b1;
        end else begin
            r_addr[k] = addr; r_sel[k] = sel; r_re[k] = 1'b1;
        end
        wait_ack(k, wr, 0, n);
        w_we[k] = 1'b0;
        r_re[k] = 1'b0;
        check(wr ? "wr_latency" : "rd_latency", n, (k == 0) ? 32'd2 : 32'd4);
        @(posedge clk);
        @(negedge clk);
        check("ack_one_cycle", {31'b0, r_ack[k] | w_ack[k]}, 32'h0);
        if (!wr) check("rdata_hold", r_data[k], exp);
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  n;
        sb_t e;
        for (int k = 0; k < 2; k++) begin
            r_addr[k] = 32'h0; r_sel[k] = 4'h0; r_re[k] = 1'b0;
            w_addr[k] = 32'h0; w_sel[k] = 4'h0; w_data[k] = 32'h0; w_we[k] = 1'b0;
            prev_any[k] = 1'b0;
        end
        vecs[0]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0011, 4'b0001, 32'h0000_00AA, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0,         32'hDEAD_AAEF};
        vecs[4]  = '{1'b0, 32'h0000_0011, 4'b0011, 32'h0,         32'h0000_ADAA};
        vecs[5]  = '{1'b1, 32'h0000_0FFE, 4'b1111, 32'h1122_3344, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0FFE, 4'b1111, 32'h0,         32'h1122_3344};
        vecs[7]  = '{1'b0, 32'h0000_0000, 4'b0001, 32'h0,         32'h0000_0022};
        vecs[8]  = '{1'b0, 32'h0000_0001, 4'b0001, 32'h0,         32'h0000_0011};
        vecs[9]  = '{1'b0, 32'h0000_1FFE, 4'b1111, 32'h0,         32'h1122_3344};
        vecs[10] = '{1'b0, 32'h0000_0FFF, 4'b0110, 32'h0,         32'h0011_2200};
        vecs[11] = '{1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 32'h0};
        vecs[12] = '{1'b0, 32'h0000_0010, 4'b0101, 32'h0,         32'h00AD_00EF};

        rst1 = 1'b1;
        rst3 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_rack", {31'b0, r_ack[k]}, 32'h0);
            check("reset_wack", {31'b0, w_ack[k]}, 32'h0);
            check("reset_rdata", r_data[k], 32'h0);
        end
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);

        // LATENCY=1: basic, partial-lane, wrap and alias accesses
        for (int i = 0; i < 13; i++) begin
            do_op(0, vecs[i].wr, vecs[i].addr, vecs[i].sel, vecs[i].wdata, vecs[i].exp);
        end

        // Simultaneous write and read: write first, read accepted afterwards
        e.wr = 1'b1; e.rdata = 32'h0; q0.push_back(e);
        e.wr = 1'b0; e.rdata = 32'hDEAD_AAEF; q0.push_back(e);
        w_addr[0] = 32'h20; w_sel[0] = 4'hF; w_data[0] = 32'h1234_5678; w_we[0] = 1'b1;
        r_addr[0] = 32'h10; r_sel[0] = 4'hF; r_re[0] = 1'b1;
        wait_ack(0, 1'b1, 0, n);
        w_we[0] = 1'b0;
        check("t4_wack_latency", n, 32'd2);
        wait_ack(0, 1'b0, n, n);
        r_re[0] = 1'b0;
        check("t4_rack_latency", n, 32'd5);
        @(posedge clk);
        @(negedge clk);
        do_op(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'h1234_5678);

        // LATENCY=3: known contents first
        do_op(1, 1'b1, 32'h40, 4'hF, 32'hCAFE_F00D, 32'h0);
        do_op(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'hCAFE_F00D);

        // Drop we in the second WAIT cycle; a read raised then shows IDLE next cycle
        w_addr[1] = 32'h40; w_sel[1] = 4'b0001; w_data[1] = 32'h0000_0099; w_we[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        w_we[1] = 1'b0;
        e.wr = 1'b0; e.rdata = 32'hCAFE_F00D; q1.push_back(e);
        r_addr[1] = 32'h40; r_sel[1] = 4'hF; r_re[1] = 1'b1;
        wait_ack(1, 1'b0, 0, n);
        r_re[1] = 1'b0;
        check("t5_abort_then_read", n, 32'd5);
        @(posedge clk);
        @(negedge clk);

        // Reset during WAIT of a write: write dropped, outputs cleared
        w_addr[1] = 32'h40; w_sel[1] = 4'b0001; w_data[1] = 32'h0000_0077; w_we[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst3 = 1'b0;
        w_we[1] = 1'b0;
        check("t6_rack_after_rst", {31'b0, r_ack[1]}, 32'h0);
        check("t6_wack_after_rst", {31'b0, w_ack[1]}, 32'h0);
        check("t6_rdata_after_rst", r_data[1], 32'h0);
        do_op(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'hCAFE_F00D);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_drained_l1", q0.size(), 32'd0);
        check("sb_drained_l3", q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
